gcd_feeder: RTL and testbench

Front-end and result stage wrapped around the `gcd` core. It accepts operand pairs over a valid/ready stream and buffers them in an internal FIFO. It issues them one at a time to the core's `start`/`a`/`b` inputs, collects each result through the core's `res_rdy`/`res_fetch` handshake, and presents results in order on an output valid/ready stream. It is the only block that drives the core's control inputs.

---
 rtl/gcd_feeder_if.sv | 28 ++
 rtl/gcd_feeder.sv | 142 ++++++++++++++
 tb/tb_gcd_feeder.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_feeder_if.sv
// Stream and core-control bundle for gcd_feeder.
// slave = feeder side, master = environment (producer, consumer and gcd core).
interface gcd_feeder_if;
    logic       in_valid;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_res;
    logic       out_ready;
    logic       busy;
    logic       gcd_start;
    logic [7:0] gcd_a;
    logic [7:0] gcd_b;
    logic       gcd_res_rdy;
    logic [7:0] gcd_res;
    logic       gcd_res_fetch;

    modport slave (
        input  in_valid, in_a, in_b, out_ready, gcd_res_rdy, gcd_res,
        output in_ready, out_valid, out_res, busy, gcd_start, gcd_a, gcd_b, gcd_res_fetch
    );

    modport master (
        output in_valid, in_a, in_b, out_ready, gcd_res_rdy, gcd_res,
        input  in_ready, out_valid, out_res, busy, gcd_start, gcd_a, gcd_b, gcd_res_fetch
    );
endinterface

// File: rtl/gcd_feeder.sv
// Operand FIFO, issue FSM and result register around an external gcd core.
// Optional GCD_FEEDER_ZERO_BYPASS_EN resolves zero-operand pairs without the core.
module gcd_feeder #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    gcd_feeder_if.slave io_bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [AW:0] ptr_t;
    localparam ptr_t PtrOne = ptr_t'(1);

    typedef enum logic [1:0] {StIdle, StStart, StWait} state_t;

    logic [7:0] r_mem_a [DEPTH];
    logic [7:0] r_mem_b [DEPTH];
    ptr_t       r_wptr;
    ptr_t       r_rptr;
    state_t     r_state;
    state_t     w_state_d;
    logic [7:0] r_gcd_a;
    logic [7:0] r_gcd_b;
    logic [7:0] r_out_res;
    logic       r_out_valid;

    logic       w_empty;
    logic       w_full;
    logic       w_push;
    logic       w_pop;
    logic       w_load;
    logic       w_fetch;
    logic       w_bypass;
    logic       w_slot_free;
    logic [7:0] w_head_a;
    logic [7:0] w_head_b;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign w_empty     = (r_wptr == r_rptr);
    assign w_full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_push      = io_bus.in_valid && !w_full;
    assign w_slot_free = !r_out_valid || io_bus.out_ready;
    assign w_head_a    = r_mem_a[r_rptr[AW-1:0]];
    assign w_head_b    = r_mem_b[r_rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wptr[AW-1:0]] <= io_bus.in_a;
            r_mem_b[r_wptr[AW-1:0]] <= io_bus.in_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PtrOne;
            if (w_pop)  r_rptr <= r_rptr + PtrOne;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_pop     = 1'b0;
        w_load    = 1'b0;
        w_fetch   = 1'b0;
        w_bypass  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!w_empty) begin
`ifdef GCD_FEEDER_ZERO_BYPASS_EN
                    // A zero pair waits in IDLE until the output slot frees up.
                    if ((w_head_a == 8'd0) || (w_head_b == 8'd0)) begin
                        if (w_slot_free) begin
                            w_pop    = 1'b1;
                            w_bypass = 1'b1;
                        end
                    end else begin
                        w_pop     = 1'b1;
                        w_load    = 1'b1;
                        w_state_d = StStart;
                    end
`else
                    w_pop     = 1'b1;
                    w_load    = 1'b1;
                    w_state_d = StStart;
`endif
                end
            end
            StStart: w_state_d = StWait;
            StWait: begin
                w_fetch = io_bus.gcd_res_rdy && w_slot_free;
                if (w_fetch) w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gcd_a <= 8'd0;
            r_gcd_b <= 8'd0;
        end else if (w_load) begin
            r_gcd_a <= w_head_a;
            r_gcd_b <= w_head_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_res   <= 8'd0;
        end else if (w_fetch) begin
            r_out_valid <= 1'b1;
            r_out_res   <= io_bus.gcd_res;
        end else if (w_bypass) begin
            r_out_valid <= 1'b1;
            r_out_res   <= w_head_a | w_head_b;
        end else if (io_bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign io_bus.in_ready      = !w_full;
    assign io_bus.out_valid     = r_out_valid;
    assign io_bus.out_res       = r_out_res;
    assign io_bus.busy          = !w_empty || (r_state != StIdle) || r_out_valid;
    assign io_bus.gcd_start     = (r_state == StStart);
    assign io_bus.gcd_a         = r_gcd_a;
    assign io_bus.gcd_b         = r_gcd_b;
    assign io_bus.gcd_res_fetch = w_fetch;
endmodule

// File: tb/tb_gcd_feeder.sv
// Directed and random checks of gcd_feeder against a behavioural gcd core.
module tb_gcd_feeder;
    localparam int CoreLat = 5;
`ifdef GCD_FEEDER_ZERO_BYPASS_EN
    localparam int ExpZeroStarts = 0;
`else
    localparam int ExpZeroStarts = 2;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gcd_feeder_if bus_if ();

    gcd_feeder #(.DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io_bus(bus_if)
    );

    int n_tests = 0;
    int n_fail = 0;
    int n_start = 0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    function automatic logic [7:0] gcd_ref(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] t;
        x = a;
        y = b;
        while (y != 8'd0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Behavioural core: result ready CoreLat cycles after start, held until fetched.
    logic [7:0] c_a, c_b;
    int c_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_cnt <= 0;
            c_a <= 8'd0;
            c_b <= 8'd0;
            bus_if.gcd_res_rdy <= 1'b0;
            bus_if.gcd_res <= 8'd0;
        end else begin
            if (bus_if.gcd_start) begin
                c_a <= bus_if.gcd_a;
                c_b <= bus_if.gcd_b;
                c_cnt <= CoreLat;
            end else if (c_cnt != 0) begin
                c_cnt <= c_cnt - 1;
                if (c_cnt == 1) begin
                    bus_if.gcd_res_rdy <= 1'b1;
                    bus_if.gcd_res <= gcd_ref(c_a, c_b);
                end
            end
            if (bus_if.gcd_res_fetch) bus_if.gcd_res_rdy <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (bus_if.gcd_start) n_start++;
            if (bus_if.out_valid && bus_if.out_ready) got.push_back(bus_if.out_res);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
        bus_if.in_valid = 1'b1;
        bus_if.in_a = a;
        bus_if.in_b = b;
        for (int i = 0; i < 200; i++) begin
            if (bus_if.in_ready) break;
            step();
        end
        chk("push_ready", 32'(bus_if.in_ready), 32'd1);
        step();
    endtask

    task automatic wait_results(input string tag, input int base, input int n);
        for (int i = 0; i < 500; i++) begin
            if (got.size() >= base + n) break;
            step();
        end
        chk(tag, 32'(got.size() - base), 32'(n));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_in_ready"}, 32'(bus_if.in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(bus_if.out_valid), 32'd0);
        chk({tag, "_out_res"}, 32'(bus_if.out_res), 32'd0);
        chk({tag, "_busy"}, 32'(bus_if.busy), 32'd0);
        chk({tag, "_start"}, 32'(bus_if.gcd_start), 32'd0);
        chk({tag, "_gcd_a"}, 32'(bus_if.gcd_a), 32'd0);
        chk({tag, "_gcd_b"}, 32'(bus_if.gcd_b), 32'd0);
        chk({tag, "_fetch"}, 32'(bus_if.gcd_res_fetch), 32'd0);
    endtask

    initial begin
        int base;
        int s0;
        int pushed;
        int cycles;
        int bad;
        logic [7:0] ra, rb;

        bus_if.in_valid = 1'b0;
        bus_if.in_a = 8'd0;
        bus_if.in_b = 8'd0;
        bus_if.out_ready = 1'b1;
        repeat (3) step();
        chk_reset_state("rst");
        rst_n = 1'b1;
        step();

        // Single pair with exact issue timing.
        base = got.size();
        s0 = n_start;
        bus_if.in_valid = 1'b1;
        bus_if.in_a = 8'd12;
        bus_if.in_b = 8'd18;
        step();
        bus_if.in_valid = 1'b0;
        chk("t1_start_idle", 32'(bus_if.gcd_start), 32'd0);
        step();
        chk("t1_start_pulse", 32'(bus_if.gcd_start), 32'd1);
        chk("t1_gcd_a", 32'(bus_if.gcd_a), 32'd12);
        chk("t1_gcd_b", 32'(bus_if.gcd_b), 32'd18);
        step();
        chk("t1_start_end", 32'(bus_if.gcd_start), 32'd0);
        chk("t1_gcd_a_hold", 32'(bus_if.gcd_a), 32'd12);
        wait_results("t1_count", base, 1);
        chk("t1_res", 32'(got[base]), 32'd6);
        chk("t1_starts", 32'(n_start - s0), 32'd1);
        step();
        chk("t1_busy_drop", 32'(bus_if.busy), 32'd0);

        // Back-to-back pushes.
        base = got.size();
        s0 = n_start;
        push_pair(8'd255, 8'd17);
        push_pair(8'd48, 8'd36);
        push_pair(8'd7, 8'd5);
        bus_if.in_valid = 1'b0;
        wait_results("t2_count", base, 3);
        chk("t2_res0", 32'(got[base]), 32'd17);
        chk("t2_res1", 32'(got[base+1]), 32'd12);
        chk("t2_res2", 32'(got[base+2]), 32'd1);
        chk("t2_starts", 32'(n_start - s0), 32'd3);

        // Output backpressure and FIFO full.
        base = got.size();
        bus_if.out_ready = 1'b0;
        push_pair(8'd12, 8'd8);
        push_pair(8'd9, 8'd6);
        push_pair(8'd10, 8'd15);
        push_pair(8'd14, 8'd21);
        push_pair(8'd100, 8'd75);
        bus_if.in_valid = 1'b0;
        chk("t3_full", 32'(bus_if.in_ready), 32'd0);
        for (int i = 0; i < 100; i++) begin
            if (bus_if.out_valid) break;
            step();
        end
        chk("t3_valid", 32'(bus_if.out_valid), 32'd1);
        chk("t3_res_first", 32'(bus_if.out_res), 32'd4);
        for (int i = 0; i < 100; i++) begin
            if (bus_if.gcd_res_rdy) break;
            step();
        end
        chk("t3_core_rdy", 32'(bus_if.gcd_res_rdy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("t3_no_fetch", 32'(bus_if.gcd_res_fetch), 32'd0);
            chk("t3_res_hold", 32'(bus_if.out_res), 32'd4);
            step();
        end
        bus_if.out_ready = 1'b1;
        wait_results("t3_count", base, 5);
        chk("t3_res0", 32'(got[base]), 32'd4);
        chk("t3_res1", 32'(got[base+1]), 32'd3);
        chk("t3_res2", 32'(got[base+2]), 32'd5);
        chk("t3_res3", 32'(got[base+3]), 32'd7);
        chk("t3_res4", 32'(got[base+4]), 32'd25);

        // Zero operands.
        base = got.size();
        s0 = n_start;
        push_pair(8'd0, 8'd9);
        push_pair(8'd0, 8'd0);
        bus_if.in_valid = 1'b0;
        wait_results("t4_count", base, 2);
        chk("t4_res0", 32'(got[base]), 32'd9);
        chk("t4_res1", 32'(got[base+1]), 32'd0);
        chk("t4_starts", 32'(n_start - s0), 32'(ExpZeroStarts));

        // Reset while waiting on the core with two pairs queued.
        repeat (3) step();
        push_pair(8'd30, 8'd42);
        push_pair(8'd8, 8'd12);
        push_pair(8'd9, 8'd27);
        bus_if.in_valid = 1'b0;
        chk("t5_busy_pre", 32'(bus_if.busy), 32'd1);
        chk("t5_core_pending", 32'(bus_if.gcd_res_rdy), 32'd0);
        rst_n = 1'b0;
        #1;
        chk_reset_state("t5_in_rst");
        step();
        rst_n = 1'b1;
        base = got.size();
        s0 = n_start;
        step();
        chk_reset_state("t5_post");
        repeat (30) step();
        chk("t5_no_result", 32'(got.size() - base), 32'd0);
        chk("t5_no_start", 32'(n_start - s0), 32'd0);
        chk("t5_valid_low", 32'(bus_if.out_valid), 32'd0);

        // Random traffic with an in-order scoreboard.
        base = got.size();
        exp_q.delete();
        pushed = 0;
        cycles = 0;
        while (pushed < 1000 && cycles < 60000) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) ra = 8'd0;
            bus_if.in_a = ra;
            bus_if.in_b = rb;
            bus_if.in_valid = ($urandom_range(0, 9) < 7);
            bus_if.out_ready = ($urandom_range(0, 1) == 1);
            if (bus_if.in_valid && bus_if.in_ready) begin
                exp_q.push_back(gcd_ref(ra, rb));
                pushed++;
            end
            step();
            cycles++;
        end
        bus_if.in_valid = 1'b0;
        bus_if.out_ready = 1'b1;
        chk("t6_pushed", 32'(pushed), 32'd1000);
        for (int i = 0; i < 20000; i++) begin
            if (got.size() >= base + exp_q.size()) break;
            step();
        end
        repeat (20) step();
        chk("t6_count", 32'(got.size() - base), 32'(exp_q.size()));
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i >= got.size() || got[base+i] !== exp_q[i]) bad++;
        end
        chk("t6_mismatches", 32'(bad), 32'd0);
        chk("t6_idle", 32'(bus_if.busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
